// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - mdu_op_t     : 3-bit operation code presented on op_e
//   - mdu_state_t  : controller state (IDLE while the busy counter is zero)
//   - RES_*        : encodings of the E-stage result mux select (res_sel)
//   - MDU_CNT_W    : width of the busy counter
//   - is_mul/is_div: operation class helpers
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mdu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_HI  = 2'b01;
    localparam logic [1:0] RES_LO  = 2'b10;

    localparam int MDU_CNT_W = 4;

    function automatic logic is_mul(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Purely combinational arithmetic for the multiply/divide unit. Produces the
// {hi, lo} pair that an operation will eventually commit.
//   op_i      : operation code
//   rs_i/rt_i : operands (rs = multiplicand / dividend, rt = multiplier / divisor)
//   hi_i/lo_i : current architectural HI/LO (returned unchanged on divide by 0)
//   res_hi_o  : product high half, or remainder
//   res_lo_o  : product low half, or quotient
// Build option: MDU_DIV_EN includes the divider; without it the outputs are
// always the product and hi_i/lo_i are not used.
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int DataBit = 32
) (
    input  mdu_op_t              op_i,
    input  logic [DataBit-1:0]   rs_i,
    input  logic [DataBit-1:0]   rt_i,
    input  logic [DataBit-1:0]   hi_i,
    input  logic [DataBit-1:0]   lo_i,
    output logic [DataBit-1:0]   res_hi_o,
    output logic [DataBit-1:0]   res_lo_o
);

    localparam int W = DataBit;

    logic           op_signed;
    logic [2*W-1:0] mul_a;
    logic [2*W-1:0] mul_b;
    logic [2*W-1:0] product;

    assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

    // Extending both operands to 2W bits lets one unsigned multiplier serve
    // both flavours: the low 2W bits of a sign-extended product are the
    // two's-complement signed product.
    assign mul_a   = op_signed ? {{W{rs_i[W-1]}}, rs_i} : {{W{1'b0}}, rs_i};
    assign mul_b   = op_signed ? {{W{rt_i[W-1]}}, rt_i} : {{W{1'b0}}, rt_i};
    assign product = mul_a * mul_b;

`ifdef MDU_DIV_EN
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic [W-1:0] uq;
    logic [W-1:0] ur;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    // Divide magnitudes, then restore signs: quotient negative when the
    // operand signs differ, remainder follows the dividend. The overflow case
    // (most-negative / -1) falls out naturally: |a| = 2^(W-1), quotient
    // negates back to itself and the remainder is zero.
    assign a_neg = op_signed & rs_i[W-1];
    assign b_neg = op_signed & rt_i[W-1];
    assign div_a = a_neg ? -rs_i : rs_i;
    assign div_b = b_neg ? -rt_i : rt_i;

    always_comb begin
        uq = '0;
        ur = '0;
        if (div_b != '0) begin
            uq = div_a / div_b;
            ur = div_a % div_b;
        end
    end

    assign quo = (a_neg ^ b_neg) ? -uq : uq;
    assign rem = a_neg ? -ur : ur;

    always_comb begin
        res_hi_o = product[2*W-1:W];
        res_lo_o = product[W-1:0];
        if (is_div(op_i)) begin
            if (rt_i == '0) begin
                res_hi_o = hi_i;
                res_lo_o = lo_i;
            end else begin
                res_hi_o = rem;
                res_lo_o = quo;
            end
        end
    end
`else
    logic [2*W-1:0] unused_hilo;

    assign unused_hilo = {hi_i, lo_i};
    assign res_hi_o    = product[2*W-1:W];
    assign res_lo_o    = product[W-1:0];
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Sequencing controller for the execute-stage multiply/divide unit. Owns
// HI/LO, runs a fixed-latency busy counter, stalls the front end while a
// decode-stage MDU instruction would observe stale HI/LO, and drives the
// E-stage result mux select.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   op_valid_e     : E-stage MDU op is live (not stalled or flushed)
//   op_e           : operation code (mdu_op_t)
//   rs_e, rt_e     : forwarded operands
//   md_use_d       : D-stage instruction is an MDU op
//   stall          : freeze PC/IF/D, bubble into E
//   busy           : an operation is in flight
//   res_sel        : E result mux select (RES_ALU / RES_HI / RES_LO)
//   hi, lo         : architectural HI/LO
// Build option: MDU_DIV_EN enables DIV/DIVU; without it they are no-ops.
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DataBit     = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_valid_e,
    input  logic [2:0]         op_e,
    input  logic [DataBit-1:0] rs_e,
    input  logic [DataBit-1:0] rt_e,
    input  logic               md_use_d,
    output logic               stall,
    output logic               busy,
    output logic [1:0]         res_sel,
    output logic [DataBit-1:0] hi,
    output logic [DataBit-1:0] lo
);

    mdu_op_t              op;
    mdu_state_t           state;
    logic                 md_op;
    logic                 start;

    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [DataBit-1:0]   hi_q, hi_d;
    logic [DataBit-1:0]   lo_q, lo_d;
    logic [DataBit-1:0]   pend_hi_q, pend_hi_d;
    logic [DataBit-1:0]   pend_lo_q, pend_lo_d;
    logic [DataBit-1:0]   arith_hi;
    logic [DataBit-1:0]   arith_lo;

    assign op = mdu_op_t'(op_e);

    mdu_arith #(
        .DataBit (DataBit)
    ) u_arith (
        .op_i     (op),
        .rs_i     (rs_e),
        .rt_i     (rt_e),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .res_hi_o (arith_hi),
        .res_lo_o (arith_lo)
    );

    // The counter is the state: non-zero means an operation is in flight.
    assign state = (cnt_q == '0) ? ST_IDLE : ST_BUSY;

`ifdef MDU_DIV_EN
    assign md_op = is_mul(op) | is_div(op);
`else
    assign md_op = is_mul(op);
`endif

    assign start = op_valid_e & md_op & (state == ST_IDLE);
    assign busy  = (state == ST_BUSY);

    // Stall already in the start cycle: the D-stage instruction must not
    // advance into E while the operation it depends on is being launched.
    assign stall = md_use_d & (busy | start);

    always_comb begin
        res_sel = RES_ALU;
        if (op_valid_e) begin
            if (op == OP_MFHI) begin
                res_sel = RES_HI;
            end else if (op == OP_MFLO) begin
                res_sel = RES_LO;
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = is_mul(op) ? MDU_CNT_W'(MULT_CYCLES)
                                           : MDU_CNT_W'(DIV_CYCLES);
                    pend_hi_d = arith_hi;
                    pend_lo_d = arith_lo;
                end else if (op_valid_e && (op == OP_MTHI)) begin
                    hi_d = rs_e;
                end else if (op_valid_e && (op == OP_MTLO)) begin
                    lo_d = rs_e;
                end
            end
            ST_BUSY: begin
                // New ops arriving here are protocol violations and are dropped.
                cnt_d = cnt_q - MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(1)) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl. A cycle-numbered reference model holds
// HI/LO and the cycle at which an in-flight result lands; results are
// computed with 64-bit integer arithmetic. Directed scenarios are followed by
// randomized traffic. Honours MDU_DIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int N_MUL = 5;
    localparam int N_DIV = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid_e;
    logic [2:0]  op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        stall;
    logic        busy;
    logic [1:0]  res_sel;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    longint      cyc;
    longint      done_cyc;   // first cycle in which the pending result is visible

    always #5 clk = ~clk;

    mdu_ctrl #(
        .DataBit     (32),
        .MULT_CYCLES (N_MUL),
        .DIV_CYCLES  (N_DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_valid_e (op_valid_e),
        .op_e       (op_e),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .md_use_d   (md_use_d),
        .stall      (stall),
        .busy       (busy),
        .res_sel    (res_sel),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_md(input logic [2:0] op);
        bit r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
        r = r || (op == OP_DIV) || (op == OP_DIVU);
`endif
        return r;
    endfunction

    function automatic void m_compute(input logic [2:0] op, input logic [31:0] a, b,
                                      input logic [31:0] oh, ol,
                                      output logic [31:0] rh, rl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = oh;
        rl = ol;
        p  = '0;
        q  = 0;
        r  = 0;
        case (op)
            OP_MULT:  begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            OP_DIV: begin
                if (b != 32'd0) begin
                    q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0];
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    q = longint'({32'd0, a}) / longint'({32'd0, b});
                    r = longint'({32'd0, a}) % longint'({32'd0, b});
                    rh = r[31:0]; rl = q[31:0];
                end
            end
            default: begin end
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1 + 32'($urandom % 8);
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive, check combinational and registered outputs
    // against the model, then advance the model across the rising edge.
    task automatic drive_cycle(input bit v, input logic [2:0] op,
                               input logic [31:0] a, b, input bit du);
        bit         idle;
        bit         exp_stall;
        logic [1:0] exp_sel;
        @(negedge clk);
        op_valid_e = v;
        op_e       = op;
        rs_e       = a;
        rt_e       = b;
        md_use_d   = du;
        #1;
        idle      = (cyc >= done_cyc);
        exp_stall = du && (!idle || (v && m_is_md(op)));
        exp_sel   = RES_ALU;
        if (v && op == OP_MFHI) exp_sel = RES_HI;
        if (v && op == OP_MFLO) exp_sel = RES_LO;
        check("busy",    busy,    !idle);
        check("stall",   stall,   exp_stall);
        check("res_sel", res_sel, exp_sel);
        check("hi",      hi,      m_hi);
        check("lo",      lo,      m_lo);
        @(posedge clk);
        if (!idle) begin
            if (cyc + 1 == done_cyc) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (v && m_is_md(op)) begin
            m_compute(op, a, b, m_hi, m_lo, m_phi, m_plo);
            done_cyc = cyc + 1 + ((op == OP_MULT || op == OP_MULTU) ? N_MUL : N_DIV);
        end else if (v && op == OP_MTHI) begin
            m_hi = a;
        end else if (v && op == OP_MTLO) begin
            m_lo = a;
        end
        cyc++;
    endtask

    task automatic idle_cycles(input int n, input bit du);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, du);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        #1;
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        cyc = 0; done_cyc = 0;
    endtask

    initial begin
        op_valid_e = 1'b0; op_e = 3'd0; rs_e = '0; rt_e = '0; md_use_d = 1'b1;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy",  busy,  1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_hi",    hi,    32'd0);
        check("rst_lo",    lo,    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Signed / unsigned multiply of the same operands
        drive_cycle(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle_cycles(N_MUL, 1'b0);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drive_cycle(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle_cycles(N_MUL, 1'b0);
        expect_hilo("multu", 32'd1, 32'hFFFF_FFFE);

        // Divide cases
        drive_cycle(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle_cycles(N_DIV, 1'b0);
`ifdef MDU_DIV_EN
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        expect_hilo("div_off", 32'd1, 32'hFFFF_FFFE);
`endif
        drive_cycle(1'b1, OP_DIVU, 32'd77, 32'd0, 1'b1);
        idle_cycles(N_DIV, 1'b1);
`ifdef MDU_DIV_EN
        expect_hilo("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        expect_hilo("div0_off", 32'd1, 32'hFFFF_FFFE);
`endif
        drive_cycle(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle_cycles(N_DIV, 1'b0);
`ifdef MDU_DIV_EN
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);
`else
        expect_hilo("div_ovf_off", 32'd1, 32'hFFFF_FFFE);
`endif

        // Stall with MFLO waiting in D, then MFLO in E selects LO
        drive_cycle(1'b1, OP_MULT, 32'd7, 32'd6, 1'b1);
        idle_cycles(N_MUL, 1'b1);
        expect_hilo("stall_mult", 32'd0, 32'd42);
        drive_cycle(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);

        // Moves
        drive_cycle(1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0);
        expect_hilo("mthi", 32'h1234, 32'd42);
        check("mthi_busy", busy, 1'b0);
        drive_cycle(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
        drive_cycle(1'b1, OP_MTLO, 32'hDEAD, 32'd0, 1'b0);
        idle_cycles(N_MUL - 1, 1'b0);
        expect_hilo("mtlo_busy", 32'd0, 32'd15);

        // Reset in the middle of a multiply
        drive_cycle(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
        drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        op_valid_e = 1'b0; md_use_d = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy,  1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_hi",    hi,    32'd0);
        check("mid_rst_lo",    lo,    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        idle_cycles(N_MUL + 3, 1'b1);
        expect_hilo("no_commit", 32'd0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom % 4) != 0, 3'($urandom % 8), rand_word(), rand_word(),
                        ($urandom % 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the multiply/divide unit in the execute stage. It accepts mult/div/move operations from E, owns the HI/LO registers, and runs a fixed-latency busy counter. It raises the pipeline stall when a decode-stage instruction needs HI/LO during an operation, and it drives the `res_sel` select of the E-stage result 3:1 mux.

## Interface
Parameters:
- `DataBit`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (legal range 1–15).
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (legal range 1–15).

Ports:
- `clk`, in, 1, single clock; all state changes on the rising edge.
- `reset_n`, in, 1, reset, asynchronous and active-low.
- `op_valid_e`, in, 1, E-stage instruction is an MDU op and is not stalled or flushed.
- `op_e`, in, 3, operation code (`mdu_pkg`): MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- `rs_e`, in, DataBit, forwarded rs operand.
- `rt_e`, in, DataBit, forwarded rt operand.
- `md_use_d`, in, 1, D-stage instruction is any MDU op.
- `stall`, out, 1, freeze PC/IF/D and insert a bubble into E.
- `busy`, out, 1, an operation is in flight.
- `res_sel`, out, 2, E result mux select: 00 ALU, 01 HI, 10 LO. Value 11 is never driven.
- `hi`, out, DataBit, architectural HI.
- `lo`, out, DataBit, architectural LO.

## Operation
- FSM states:
  - IDLE: `cnt` == 0.
  - BUSY: `cnt` != 0.
  - `busy` = (`cnt` != 0).
- Start condition: `op_valid_e` & mult/div op & IDLE.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES.
  - The arithmetic result is latched into `pend_hi` / `pend_lo`.
- MULT/MULTU:
  - {pend_hi, pend_lo} = 2·DataBit-bit product.
  - MULT is signed; MULTU is unsigned.
- DIV/DIVU:
  - `pend_lo` = quotient, `pend_hi` = remainder.
  - Remainder takes the sign of the dividend (truncating division).
  - Divisor 0: pend_hi/pend_lo = current hi/lo, so HI/LO are unchanged. Full DIV_CYCLES latency still applies.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- BUSY: `cnt` decrements each cycle. On the edge where `cnt` == 1, hi/lo ← pend_hi/pend_lo and the FSM returns to IDLE.
- MTHI/MTLO: write `rs_e` to hi/lo on the same edge. Accepted only in IDLE.
- MFHI/MFLO: `res_sel` = 01 or 10 combinationally while `op_valid_e`; otherwise 00.
- `stall` = `md_use_d` & (`busy` | start condition). Any MDU op in D waits until HI/LO are final.
- A mult/div or MT op arriving in BUSY is a protocol violation. It is ignored: no restart, no write.
- Reset (asynchronous, at any time, including mid-operation):
  - `cnt`, hi, lo, pend_hi, pend_lo → 0.
  - `busy` = 0, `stall` = 0.
  - The in-flight operation is abandoned.

## Timing
- Start in cycle T:
  - `busy` is high in cycles T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible from T+N+1.
  - `stall` is high in T..T+N whenever `md_use_d` is high.
- MTHI/MTLO in cycle T: hi/lo are visible from T+1.
- `res_sel`, `stall` and `busy` are combinational from state and inputs. `busy` depends on state only.

## Configuration
- `MDU_DIV_EN` defined:
  - DIV/DIVU are implemented as above.
- `MDU_DIV_EN` undefined:
  - The divider logic is removed.
  - DIV/DIVU are no-ops: no busy, no stall contribution, hi/lo unchanged.
  - DIV_CYCLES is unused.

## Structure
- `mdu_pkg` holds:
  - `op_e` codes (3-bit enum).
  - `res_sel` encodings: RES_ALU = 2'b00, RES_HI = 2'b01, RES_LO = 2'b10.
  - Counter width constant `MDU_CNT_W` = 4.
- Sub-module `mdu_arith`: combinational product, quotient and remainder, including the divide-by-zero and overflow cases. The divide path sits under `MDU_DIV_EN`.
- `mdu_ctrl` holds the counter, HI/LO, the pending registers, and the stall and select logic.

## Test plan
- Reset mid-operation:
  - Stimulus: MULT 3 × 4, then drop `reset_n` low in cycle T+2.
  - Required: busy = 0, hi = lo = 0 immediately; no commit afterwards.
- Signed multiply:
  - Stimulus: MULT 0xFFFFFFFF × 2 in T.
  - Required: busy high T+1..T+5; from T+6 hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
  - Stimulus: MULTU with the same operands.
  - Required: hi = 1, lo = 0xFFFFFFFE.
- Signed divide:
  - Stimulus: DIV −7 / 2.
  - Required: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after 10 busy cycles.
  - Stimulus: divide by 0.
  - Required: hi/lo unchanged, busy still 10 cycles.
- Stall and select:
  - Stimulus: MULT in T with MFLO in D.
  - Required: stall high T..T+5; then MFLO reaches E with res_sel = 10 and lo holds the product.
- Move operations:
  - Stimulus: MTHI 0x1234 while IDLE.
  - Required: hi = 0x1234 next cycle, busy stays 0.
  - Stimulus: MTLO while BUSY.
  - Required: ignored; lo = pending result after commit.
- Configuration:
  - Stimulus: DIV with `MDU_DIV_EN` undefined.
  - Required: busy never rises, stall = 0, hi/lo unchanged.
